// File: rtl/blink_pkg.sv
// Shared constants and types for the LED blinker command receiver.
// Opcodes, reset values and FSM state encodings live here.
package blink_pkg;

    localparam logic [7:0] OP_MASK      = 8'h4C;
    localparam logic [7:0] OP_PERIOD    = 8'h50;
    localparam logic [7:0] OP_ENABLE    = 8'h45;
    localparam logic [7:0] LED_MASK_RST = 8'h81;
    localparam int         TEN_MS_DIV   = 100;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        P_WAIT_OP,
        P_WAIT_ARG
    } par_state_t;

    function automatic logic takes_arg(input logic [7:0] op);
        return (op == OP_MASK) || (op == OP_PERIOD);
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 2-flop synchroniser and mid-bit sampling.
// Emits a one-cycle byte_valid or frame_err after the stop sample.
module uart_rx_8n1
    import blink_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int            BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int            CW       = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] DIV_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] DIV_HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [1:0]    r_sync;
    logic          r_rx_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_brk;
    logic          r_valid;
    logic          r_ferr;
    logic          w_rx;
    logic          w_exp;

    assign w_rx  = r_sync[1];
    assign w_exp = (r_cnt == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_brk: a bad stop bit holds us in STOP until the line idles high
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RX_IDLE:  if (r_rx_d && !w_rx) w_state_nxt = RX_START;
            RX_START: if (w_exp) w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_exp && r_bit == 3'd7) w_state_nxt = RX_STOP;
            RX_STOP:  if (r_brk ? w_rx : (w_exp && w_rx)) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b1;
            r_cnt   <= DIV_HALF;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_brk   <= 1'b0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_rx_d  <= w_rx;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            unique case (r_state)
                RX_IDLE: begin
                    r_cnt <= DIV_HALF;
                    r_bit <= 3'd0;
                    r_brk <= 1'b0;
                end
                RX_START: begin
                    r_cnt <= w_exp ? DIV_FULL : r_cnt - CNT_ONE;
                end
                RX_DATA: begin
                    if (w_exp) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        r_cnt   <= DIV_FULL;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (r_brk) begin
                        if (w_rx) r_brk <= 1'b0;
                    end else if (w_exp) begin
                        r_valid <= w_rx;
                        r_ferr  <= !w_rx;
                        r_brk   <= !w_rx;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_cnt <= DIV_HALF;
            endcase
        end
    end

    assign data       = r_shift;
    assign byte_valid = r_valid;
    assign frame_err  = r_ferr;

endmodule

// File: rtl/blink_cmd_rx.sv
// UART command front-end for the LED blinker: parses opcode/argument
// frames into registered mask, half-period and enable outputs.
module blink_cmd_rx
    import blink_pkg::*;
#(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int ARG_TIMEOUT = CLK_FREQ / 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [7:0]  led_mask,
    output logic [31:0] half_period,
    output logic        blink_en,
    output logic        cfg_update,
    output logic        frame_err,
    output logic        cmd_err
);

    localparam int            TW         = $clog2(ARG_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(ARG_TIMEOUT - 1);
    localparam logic [31:0]   UNIT       = 32'(CLK_FREQ / TEN_MS_DIV);
    localparam logic [31:0]   PERIOD_RST = 32'(CLK_FREQ / 2);

    logic [7:0]  w_data;
    logic        w_byte_valid;
    logic        w_ferr;
    logic        w_tmo_hit;
    logic        w_as_op;
    logic [31:0] w_prod;

    par_state_t  r_state;
    par_state_t  w_state_nxt;
    logic [7:0]  r_op;
    logic [TW-1:0] r_tmo;
    logic [7:0]  r_mask;
    logic [31:0] r_period;
    logic        r_en;
    logic        r_cfg;
    logic        r_ferr;
    logic        r_cerr;

    logic [7:0]    w_op_nxt;
    logic [TW-1:0] w_tmo_nxt;
    logic [7:0]    w_mask_nxt;
    logic [31:0]   w_period_nxt;
    logic          w_en_nxt;
    logic          w_cfg_nxt;
    logic          w_ferr_nxt;
    logic          w_cerr_nxt;

    uart_rx_8n1 #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (uart_rx),
        .data       (w_data),
        .byte_valid (w_byte_valid),
        .frame_err  (w_ferr)
    );

    // A byte landing on the timeout cycle is decoded as a fresh opcode
    assign w_tmo_hit = (r_state == P_WAIT_ARG) && (r_tmo == TMO_LAST);
    assign w_as_op   = (r_state == P_WAIT_OP) || w_tmo_hit;
    assign w_prod    = {24'd0, w_data} * UNIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= P_WAIT_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_byte_valid && w_as_op) begin
            w_state_nxt = takes_arg(w_data) ? P_WAIT_ARG : P_WAIT_OP;
        end else if (w_byte_valid || w_ferr || w_tmo_hit) begin
            w_state_nxt = P_WAIT_OP;
        end
    end

    always_comb begin
        w_op_nxt     = r_op;
        w_tmo_nxt    = (r_state == P_WAIT_ARG) ? r_tmo + TW'(1) : r_tmo;
        w_mask_nxt   = r_mask;
        w_period_nxt = r_period;
        w_en_nxt     = r_en;
        w_cfg_nxt    = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_cerr_nxt   = 1'b0;
        if (w_byte_valid && w_as_op) begin
            if (w_data == OP_ENABLE) begin
                w_en_nxt  = 1'b1;
                w_cfg_nxt = 1'b1;
            end else if (takes_arg(w_data)) begin
                w_op_nxt   = w_data;
                w_tmo_nxt  = '0;
                w_cerr_nxt = w_tmo_hit;
            end else begin
                w_cerr_nxt = 1'b1;
            end
        end else if (w_byte_valid) begin
            w_cfg_nxt = 1'b1;
            if (r_op == OP_MASK) begin
                w_mask_nxt = w_data;
            end else if (w_data == 8'd0) begin
                w_en_nxt = 1'b0;
            end else begin
                w_period_nxt = w_prod;
                w_en_nxt     = 1'b1;
            end
        end else if (w_ferr) begin
            w_ferr_nxt = 1'b1;
        end else if (w_tmo_hit) begin
            w_cerr_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MASK;
            r_tmo    <= '0;
            r_mask   <= LED_MASK_RST;
            r_period <= PERIOD_RST;
            r_en     <= 1'b1;
            r_cfg    <= 1'b0;
            r_ferr   <= 1'b0;
            r_cerr   <= 1'b0;
        end else begin
            r_op     <= w_op_nxt;
            r_tmo    <= w_tmo_nxt;
            r_mask   <= w_mask_nxt;
            r_period <= w_period_nxt;
            r_en     <= w_en_nxt;
            r_cfg    <= w_cfg_nxt;
            r_ferr   <= w_ferr_nxt;
            r_cerr   <= w_cerr_nxt;
        end
    end

    assign led_mask    = r_mask;
    assign half_period = r_period;
    assign blink_en    = r_en;
    assign cfg_update  = r_cfg;
    assign frame_err   = r_ferr;
    assign cmd_err     = r_cerr;

endmodule

// File: tb/tb_blink_cmd_rx.sv
// Bench for blink_cmd_rx: directed frames plus random command traffic,
// checked every cycle against a step-based behavioural model.
module tb_blink_cmd_rx;

    localparam int CF    = 1_000_000;
    localparam int BR    = 100_000;
    localparam int TMO   = 500;
    localparam int D     = CF / BR;
    localparam int APPLY = 3 + D / 2 + 9 * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic [7:0]  led_mask;
    logic [31:0] half_period;
    logic        blink_en;
    logic        cfg_update;
    logic        frame_err;
    logic        cmd_err;

    blink_cmd_rx #(
        .CLK_FREQ    (CF),
        .BAUD_RATE   (BR),
        .ARG_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .led_mask    (led_mask),
        .half_period (half_period),
        .blink_en    (blink_en),
        .cfg_update  (cfg_update),
        .frame_err   (frame_err),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int g = 0;
    bit chk_on = 1'b0;

    logic [7:0]  m_mask;
    logic [31:0] m_period;
    logic        m_en;
    logic        m_wait_arg;
    logic [7:0]  m_op;
    int          m_deadline;
    logic        e_cfg, e_ferr, e_cerr;

    int n_cfg = 0, n_ferr = 0, n_cerr = 0, cerr_step = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (step %0d)",
                     name, act, exp, g);
        end
    endtask

    function automatic void model_reset();
        m_mask     = 8'h81;
        m_period   = CF / 2;
        m_en       = 1'b1;
        m_wait_arg = 1'b0;
        m_op       = 8'h00;
        m_deadline = 0;
        e_cfg      = 1'b0;
        e_ferr     = 1'b0;
        e_cerr     = 1'b0;
    endfunction

    function automatic void tick();
        g++;
        e_cfg  = 1'b0;
        e_ferr = 1'b0;
        e_cerr = 1'b0;
        if (m_wait_arg && g == m_deadline) begin
            m_wait_arg = 1'b0;
            e_cerr     = 1'b1;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_wait_arg) begin
            if (b == 8'h45) begin
                m_en   = 1'b1;
                e_cfg  = 1'b1;
                e_cerr = 1'b0;
            end else if (b == 8'h4C || b == 8'h50) begin
                m_op       = b;
                m_wait_arg = 1'b1;
                m_deadline = g + TMO;
            end else begin
                e_cerr = 1'b1;
            end
        end else begin
            m_wait_arg = 1'b0;
            e_cfg      = 1'b1;
            if (m_op == 8'h4C) m_mask = b;
            else if (b == 8'h00) m_en = 1'b0;
            else begin
                m_period = b * (CF / 100);
                m_en     = 1'b1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("led_mask", led_mask, m_mask);
            chk("half_period", half_period, m_period);
            chk("blink_en", blink_en, m_en);
            chk("cfg_update", cfg_update, e_cfg);
            chk("frame_err", frame_err, e_ferr);
            chk("cmd_err", cmd_err, e_cerr);
            if (cfg_update === 1'b1) n_cfg++;
            if (frame_err === 1'b1) n_ferr++;
            if (cmd_err === 1'b1) begin
                n_cerr++;
                cerr_step = g;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            tick();
            uart_rx = 1'b1;
        end
    endtask

    // abort_at >= 0 drops rst_n at that step of the frame
    task automatic send(input logic [7:0] b, input logic stop_bit,
                        input int abort_at);
        int k;
        for (int j = 0; j < 10 * D; j++) begin
            @(negedge clk);
            #1;
            tick();
            if (j == abort_at) begin
                rst_n   = 1'b0;
                uart_rx = 1'b1;
                model_reset();
                return;
            end
            if (j % D == 0) begin
                k = j / D;
                uart_rx = (k == 0) ? 1'b0 : (k < 9) ? b[k-1] : stop_bit;
            end
            if (j == APPLY) begin
                if (stop_bit) model_byte(b);
                else begin
                    e_ferr     = 1'b1;
                    m_wait_arg = 1'b0;
                end
            end
        end
    endtask

    int s_op;
    int gap;
    int r;
    logic [7:0] rb;

    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        chk("rst_mask", led_mask, 32'h81);
        chk("rst_period", half_period, 32'd500000);
        chk("rst_en", blink_en, 32'd1);
        chk("rst_pulses", {cfg_update, frame_err, cmd_err}, 32'd0);

        send(8'h4C, 1'b1, -1);
        send(8'h3C, 1'b1, -1);
        idle(5);
        chk("mask_3c", led_mask, 32'h3C);
        chk("mask_period", half_period, 32'd500000);
        chk("mask_cfg_cnt", n_cfg, 32'd1);

        send(8'h50, 1'b1, -1);
        send(8'h05, 1'b1, -1);
        idle(5);
        chk("p5_period", half_period, 32'd50000);
        chk("p5_en", blink_en, 32'd1);
        send(8'h50, 1'b1, -1);
        send(8'h00, 1'b1, -1);
        idle(5);
        chk("p0_en", blink_en, 32'd0);
        chk("p0_period", half_period, 32'd50000);
        send(8'h45, 1'b1, -1);
        idle(5);
        chk("e_en", blink_en, 32'd1);

        send(8'h41, 1'b1, -1);
        idle(5);
        chk("bad_op_cnt", n_cerr, 32'd1);
        chk("bad_op_mask", led_mask, 32'h3C);
        send(8'h4C, 1'b0, -1);
        idle(12);
        chk("ferr_cnt", n_ferr, 32'd1);
        send(8'h4C, 1'b1, -1);
        send(8'hFF, 1'b1, -1);
        idle(5);
        chk("mask_ff", led_mask, 32'hFF);

        @(negedge clk); #1; tick(); uart_rx = 1'b0;
        @(negedge clk); #1; tick(); uart_rx = 1'b0;
        idle(30);
        chk("glitch_cfg", n_cfg, 32'd5);
        chk("glitch_cerr", n_cerr, 32'd1);
        chk("glitch_ferr", n_ferr, 32'd1);

        s_op = g + 1;
        send(8'h4C, 1'b1, -1);
        idle(600);
        chk("tmo_cnt", n_cerr, 32'd2);
        chk("tmo_at", cerr_step - s_op, 32'd598);
        send(8'h12, 1'b1, -1);
        idle(5);
        chk("post_tmo_cerr", n_cerr, 32'd3);
        chk("post_tmo_mask", led_mask, 32'hFF);

        send(8'h50, 1'b1, -1);
        send(8'h00, 1'b1, 4 * D + D + 5);
        #1;
        chk("midrst_mask", led_mask, 32'h81);
        chk("midrst_period", half_period, 32'd500000);
        chk("midrst_en", blink_en, 32'd1);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        send(8'h4C, 1'b1, -1);
        send(8'h01, 1'b1, -1);
        idle(5);
        chk("post_rst_mask", led_mask, 32'h01);

        for (int it = 0; it < 80; it++) begin
            r  = int'($urandom_range(0, 9));
            rb = (r < 3) ? 8'h4C : (r < 6) ? 8'h50 : (r == 6) ? 8'h45 :
                 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                send(rb, 1'b0, -1);
                idle(10 + int'($urandom_range(0, 10)));
            end else begin
                send(rb, 1'b1, -1);
                gap = ($urandom_range(0, 7) == 0) ?
                      int'($urandom_range(550, 650)) :
                      int'($urandom_range(0, 40));
                idle(gap);
            end
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
